// File: rtl/alu_nextpc_unit.sv
// Execution and next-PC slice of a single-cycle MIPS-style processor.
// Holds the PC and the previous-ALU-result registers, the PC+4 and
// branch-target adders, the 32-bit ALU with zero flag, and the
// branch-control mux that selects the next PC.
// Register file, data memory, decode and operand muxing live outside.
// There are no handshakes here: one instruction completes per clock,
// and the unit never stalls.
module alu_nextpc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] aluin1,
  input  logic [31:0] aluin2,
  input  logic [2:0]  alu_op,
  input  logic [2:0]  branch,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  logic [31:0] reg1,
  input  logic [31:0] mem_data,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] aluout,
  output logic        zout,
  output logic [31:0] prev_aluout,
  output logic [31:0] next_pc
);

  // ALU operation encodings {alu2,alu1,alu0}
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Branch-control encodings {branch2,branch1,branch0}
  localparam logic [2:0] BR_SEQ  = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BMN  = 3'b010;
  localparam logic [2:0] BR_BRZ  = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;
  localparam logic [2:0] BR_JM   = 3'b101;
  localparam logic [2:0] BR_JMOR = 3'b110;
  localparam logic [2:0] BR_JR   = 3'b111;

  logic [31:0] imm_ext;
  logic [31:0] pc_imm;
  logic [31:0] target_addr;
  logic        flag_n;
  logic        flag_z;

  // Address arithmetic; all sums wrap modulo 2^32.
  assign pc4         = pc + 32'd4;
  assign imm_ext     = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc_imm      = pc4 + imm_ext;
  assign target_addr = {pc4[31:28], jaddr, 2'b00};

  // Condition flags come from the previous instruction's result, not this
  // cycle's ALU, so a branch tests what the instruction before it computed.
  assign flag_n = prev_aluout[31];
  assign flag_z = (prev_aluout == 32'd0);

  // ALU datapath; the unused encodings 100 and 101 produce zero.
  always_comb begin
    aluout = 32'd0;
    case (alu_op)
      ALU_AND: aluout = aluin1 & aluin2;
      ALU_OR:  aluout = aluin1 | aluin2;
      ALU_ADD: aluout = aluin1 + aluin2;
      ALU_SRL: aluout = aluin1 >> aluin2[4:0];
      ALU_SUB: aluout = aluin1 - aluin2;
      ALU_SLT: aluout = ($signed(aluin1) < $signed(aluin2)) ? 32'd1 : 32'd0;
      default: aluout = 32'd0;
    endcase
  end

  assign zout = (aluout == 32'd0);

  // Next-PC selection; conditional forms fall back to pc4 when not taken.
  always_comb begin
    next_pc = pc4;
    case (branch)
      BR_SEQ:  next_pc = pc4;
      BR_BEQ:  next_pc = zout   ? pc_imm      : pc4;
      BR_BMN:  next_pc = flag_n ? mem_data    : pc4;
      BR_BRZ:  next_pc = flag_z ? reg1        : pc4;
      BR_BZ:   next_pc = flag_z ? target_addr : pc4;
      BR_JM:   next_pc = mem_data;
      BR_JMOR: next_pc = mem_data;
      BR_JR:   next_pc = reg1;
      default: next_pc = pc4;
    endcase
  end

  // PC and previous-result registers; reset overrides the in-flight next_pc.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      prev_aluout <= 32'd0;
    end else begin
      pc          <= next_pc;
      prev_aluout <= aluout;
    end
  end

endmodule

// File: tb/tb_alu_nextpc_unit.sv
// Directed self-checking bench for alu_nextpc_unit.
// Inputs change just after a rising edge; outputs are sampled #1 later,
// well away from the next active edge.
module tb_alu_nextpc_unit;

  logic        clock;
  logic        reset;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  alu_op;
  logic [2:0]  branch;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic [31:0] reg1;
  logic [31:0] mem_data;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] aluout;
  logic        zout;
  logic [31:0] prev_aluout;
  logic [31:0] next_pc;

  int checks   = 0;
  int failures = 0;

  alu_nextpc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .aluin1      (aluin1),
    .aluin2      (aluin2),
    .alu_op      (alu_op),
    .branch      (branch),
    .imm16       (imm16),
    .jaddr       (jaddr),
    .reg1        (reg1),
    .mem_data    (mem_data),
    .pc          (pc),
    .pc4         (pc4),
    .aluout      (aluout),
    .zout        (zout),
    .prev_aluout (prev_aluout),
    .next_pc     (next_pc)
  );

  // Clock generation: 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver: advance one clock and settle past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Driver: apply ALU operands and operation.
  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    aluin1 = a;
    aluin2 = b;
    #1;
  endtask

  // Driver: apply branch controls.
  task automatic set_br(input logic [2:0] br, input logic [15:0] imm, input logic [25:0] ja,
                        input logic [31:0] r1, input logic [31:0] md);
    branch   = br;
    imm16    = imm;
    jaddr    = ja;
    reg1     = r1;
    mem_data = md;
    #1;
  endtask

  task automatic do_reset();
    set_alu(3'b000, 32'd0, 32'd0);
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
    checks++; if (prev_aluout !== 32'h0) begin failures++; $display("FAIL reset_prev: got %h exp %h", prev_aluout, 32'h0); end
    checks++; if (pc4 !== 32'h4) begin failures++; $display("FAIL reset_pc4: got %h exp %h", pc4, 32'h4); end
    // Z=1 after reset, so bz and brz are taken; N=0 so bmn is not.
    set_br(3'b100, 16'd0, 26'd5, 32'd0, 32'd0);
    checks++; if (next_pc !== 32'h14) begin failures++; $display("FAIL reset_bz_taken: got %h exp %h", next_pc, 32'h14); end
    set_br(3'b011, 16'd0, 26'd0, 32'h24, 32'd0);
    checks++; if (next_pc !== 32'h24) begin failures++; $display("FAIL reset_brz_taken: got %h exp %h", next_pc, 32'h24); end
    set_br(3'b010, 16'd0, 26'd0, 32'd0, 32'h30);
    checks++; if (next_pc !== 32'h4) begin failures++; $display("FAIL reset_bmn_not: got %h exp %h", next_pc, 32'h4); end
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic test_alu();
    set_alu(3'b010, 32'haa, 32'h11);
    checks++; if (aluout !== 32'hbb || zout !== 1'b0) begin failures++; $display("FAIL alu_add: got %h z%b exp %h z0", aluout, zout, 32'hbb); end
    set_alu(3'b110, 32'h55, 32'h22);
    checks++; if (aluout !== 32'h33) begin failures++; $display("FAIL alu_sub: got %h exp %h", aluout, 32'h33); end
    set_alu(3'b000, 32'hff, 32'h88);
    checks++; if (aluout !== 32'h88) begin failures++; $display("FAIL alu_and: got %h exp %h", aluout, 32'h88); end
    set_alu(3'b001, 32'ha0, 32'h0b);
    checks++; if (aluout !== 32'hab) begin failures++; $display("FAIL alu_or: got %h exp %h", aluout, 32'hab); end
    set_alu(3'b111, 32'h1, 32'h10);
    checks++; if (aluout !== 32'h1) begin failures++; $display("FAIL alu_slt_pos: got %h exp %h", aluout, 32'h1); end
    set_alu(3'b111, 32'hffffffff, 32'h1);
    checks++; if (aluout !== 32'h1) begin failures++; $display("FAIL alu_slt_signed: got %h exp %h", aluout, 32'h1); end
    set_alu(3'b111, 32'h10, 32'h1);
    checks++; if (aluout !== 32'h0 || zout !== 1'b1) begin failures++; $display("FAIL alu_slt_false: got %h z%b exp 0 z1", aluout, zout); end
    set_alu(3'b011, 32'haa00, 32'h4);
    checks++; if (aluout !== 32'h0aa0) begin failures++; $display("FAIL alu_srl: got %h exp %h", aluout, 32'h0aa0); end
    set_alu(3'b011, 32'h80000000, 32'h3f);
    checks++; if (aluout !== 32'h1) begin failures++; $display("FAIL alu_srl_mask: got %h exp %h", aluout, 32'h1); end
    set_alu(3'b100, 32'hff, 32'hff);
    checks++; if (aluout !== 32'h0 || zout !== 1'b1) begin failures++; $display("FAIL alu_op100: got %h z%b exp 0 z1", aluout, zout); end
    set_alu(3'b101, 32'h12, 32'h34);
    checks++; if (aluout !== 32'h0) begin failures++; $display("FAIL alu_op101: got %h exp 0", aluout); end
  endtask

  task automatic test_beq();
    do_reset();
    set_alu(3'b010, 32'h1, 32'h1);
    step();
    step();
    checks++; if (pc !== 32'h8) begin failures++; $display("FAIL beq_setup_pc: got %h exp %h", pc, 32'h8); end
    set_alu(3'b110, 32'hef, 32'hef);
    set_br(3'b001, 16'h0001, 26'd0, 32'd0, 32'd0);
    checks++; if (zout !== 1'b1 || next_pc !== 32'h10) begin failures++; $display("FAIL beq_taken: got z%b %h exp z1 %h", zout, next_pc, 32'h10); end
    set_alu(3'b110, 32'hef, 32'hee);
    checks++; if (next_pc !== 32'hc) begin failures++; $display("FAIL beq_not: got %h exp %h", next_pc, 32'hc); end
    // imm16 = -1 brings the target back to the branch itself.
    set_alu(3'b110, 32'hef, 32'hef);
    set_br(3'b001, 16'hffff, 26'd0, 32'd0, 32'd0);
    checks++; if (next_pc !== 32'h8) begin failures++; $display("FAIL beq_self: got %h exp %h", next_pc, 32'h8); end
    set_br(3'b001, 16'hfffc, 26'd0, 32'd0, 32'd0);
    checks++; if (next_pc !== 32'hfffffffc) begin failures++; $display("FAIL beq_backward: got %h exp %h", next_pc, 32'hfffffffc); end
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic test_bmn();
    // pc = 0x8 from previous test
    set_alu(3'b110, 32'h22, 32'h23);
    checks++; if (aluout !== 32'hffffffff) begin failures++; $display("FAIL bmn_sub: got %h exp %h", aluout, 32'hffffffff); end
    step();
    checks++; if (pc !== 32'hc || prev_aluout !== 32'hffffffff) begin failures++; $display("FAIL bmn_regs: got pc %h prev %h exp c ffffffff", pc, prev_aluout); end
    set_alu(3'b010, 32'h1, 32'h1);
    set_br(3'b010, 16'd0, 26'd0, 32'd0, 32'h14);
    checks++; if (next_pc !== 32'h14) begin failures++; $display("FAIL bmn_taken: got %h exp %h", next_pc, 32'h14); end
    step();
    checks++; if (pc !== 32'h14 || prev_aluout !== 32'h2) begin failures++; $display("FAIL bmn_after: got pc %h prev %h exp 14 2", pc, prev_aluout); end
    set_br(3'b010, 16'd0, 26'd0, 32'd0, 32'h40);
    checks++; if (next_pc !== 32'h18) begin failures++; $display("FAIL bmn_not: got %h exp %h", next_pc, 32'h18); end
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic test_brz_bz();
    do_reset();
    set_alu(3'b110, 32'h22, 32'h22);
    step();
    step();
    checks++; if (pc !== 32'h8 || prev_aluout !== 32'h0) begin failures++; $display("FAIL z_setup: got pc %h prev %h exp 8 0", pc, prev_aluout); end
    set_br(3'b011, 16'd0, 26'd0, 32'h14, 32'd0);
    checks++; if (next_pc !== 32'h14) begin failures++; $display("FAIL brz_taken: got %h exp %h", next_pc, 32'h14); end
    set_br(3'b100, 16'd0, 26'd5, 32'd0, 32'd0);
    checks++; if (next_pc !== 32'h14) begin failures++; $display("FAIL bz_taken: got %h exp %h", next_pc, 32'h14); end
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
    set_alu(3'b010, 32'h1, 32'h2);
    step();
    set_br(3'b011, 16'd0, 26'd0, 32'h14, 32'd0);
    checks++; if (next_pc !== 32'h10) begin failures++; $display("FAIL brz_not: got %h exp %h", next_pc, 32'h10); end
    set_br(3'b100, 16'd0, 26'd5, 32'd0, 32'd0);
    checks++; if (next_pc !== 32'h10) begin failures++; $display("FAIL bz_not: got %h exp %h", next_pc, 32'h10); end
    set_br(3'b000, 16'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic test_jumps();
    // pc = 0xc from previous test
    set_alu(3'b001, 32'h10, 32'h8);
    set_br(3'b110, 16'd0, 26'd0, 32'd0, 32'h14);
    checks++; if (aluout !== 32'h18) begin failures++; $display("FAIL jmor_addr: got %h exp %h", aluout, 32'h18); end
    checks++; if (next_pc !== 32'h14 || pc4 !== 32'h10) begin failures++; $display("FAIL jmor_target: got %h link %h exp 14 10", next_pc, pc4); end
    step();
    checks++; if (pc !== 32'h14) begin failures++; $display("FAIL jmor_pc: got %h exp %h", pc, 32'h14); end
    set_br(3'b111, 16'd0, 26'd0, 32'h40, 32'h0);
    checks++; if (next_pc !== 32'h40) begin failures++; $display("FAIL jr_target: got %h exp %h", next_pc, 32'h40); end
    step();
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL jr_pc: got %h exp %h", pc, 32'h40); end
    set_br(3'b101, 16'd0, 26'd0, 32'h0, 32'h80);
    checks++; if (next_pc !== 32'h80) begin failures++; $display("FAIL jm_target: got %h exp %h", next_pc, 32'h80); end
  endtask

  task automatic test_wrap();
    set_br(3'b111, 16'd0, 26'd0, 32'hfffffffc, 32'h0);
    step();
    set_br(3'b000, 16'd0, 26'd0, 32'h0, 32'h0);
    checks++; if (pc !== 32'hfffffffc || pc4 !== 32'h0 || next_pc !== 32'h0) begin failures++; $display("FAIL wrap_top: got pc %h pc4 %h np %h exp fffffffc 0 0", pc, pc4, next_pc); end
    step();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc: got %h exp 0", pc); end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    set_alu(3'b010, 32'h5, 32'h6);
    step();
    step();
    step();
    checks++; if (pc !== 32'hc || prev_aluout !== 32'hb) begin failures++; $display("FAIL midreset_setup: got pc %h prev %h exp c b", pc, prev_aluout); end
    set_br(3'b111, 16'd0, 26'd0, 32'h100, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_br(3'b000, 16'd0, 26'd0, 32'h0, 32'h0);
    checks++; if (pc !== 32'h0 || prev_aluout !== 32'h0) begin failures++; $display("FAIL midreset_regs: got pc %h prev %h exp 0 0", pc, prev_aluout); end
    checks++; if (next_pc !== 32'h4) begin failures++; $display("FAIL midreset_next: got %h exp %h", next_pc, 32'h4); end
    step();
    checks++; if (pc !== 32'h4) begin failures++; $display("FAIL midreset_resume: got %h exp %h", pc, 32'h4); end
  endtask

  initial begin
    reset    = 1'b1;
    aluin1   = 32'd0;
    aluin2   = 32'd0;
    alu_op   = 3'b000;
    branch   = 3'b000;
    imm16    = 16'd0;
    jaddr    = 26'd0;
    reg1     = 32'd0;
    mem_data = 32'd0;
    test_reset();
    test_alu();
    test_beq();
    test_bmn();
    test_brz_bz();
    test_jumps();
    test_wrap();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
